// File: rtl/buffer_reader_pkg.sv
// Shared definitions for the weight-buffer reader: buffer geometry and FSM states.
package buffer_reader_pkg;

    localparam int BUF_DEPTH = 16;
    localparam int BUF_IDX_W = 4;
    localparam int WORD_W    = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/buffer_reader_next_set_finder.sv
// Finds the lowest set mask bit above (or, when inclusive, at or above) a start index.
// Inclusive search from index 0 gives the first emitted entry of a stream.
module buffer_reader_next_set_finder
    import buffer_reader_pkg::*;
(
    input  logic [BUF_DEPTH-1:0] mask,
    input  logic [BUF_IDX_W-1:0] from_index,
    input  logic                 inclusive,
    output logic [BUF_IDX_W-1:0] nxt_index,
    output logic                 none
);

    logic [BUF_DEPTH-1:0] cand;

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_cand
            assign cand[gi] = mask[gi] &&
                              ((BUF_IDX_W'(gi) > from_index) ||
                               (inclusive && (BUF_IDX_W'(gi) == from_index)));
        end
    endgenerate

    // Priority encode the lowest candidate; scanning downward lets the lowest win.
    always_comb begin
        nxt_index = '0;
        for (int i = BUF_DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                nxt_index = BUF_IDX_W'(i);
            end
        end
        none = ~|cand;
    end

endmodule

// File: rtl/buffer_reader.sv
// Snapshots the 16-entry weight buffer on start and streams the entries out over
// valid/ready, optionally skipping zero entries.
module buffer_reader
    import buffer_reader_pkg::*;
#(
    parameter int          WIDTH     = WORD_W,
    parameter int unsigned SKIP_ZERO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] W0,
    input  logic [WIDTH-1:0] W1,
    input  logic [WIDTH-1:0] W2,
    input  logic [WIDTH-1:0] W3,
    input  logic [WIDTH-1:0] W4,
    input  logic [WIDTH-1:0] W5,
    input  logic [WIDTH-1:0] W6,
    input  logic [WIDTH-1:0] W7,
    input  logic [WIDTH-1:0] W8,
    input  logic [WIDTH-1:0] W9,
    input  logic [WIDTH-1:0] W10,
    input  logic [WIDTH-1:0] W11,
    input  logic [WIDTH-1:0] W12,
    input  logic [WIDTH-1:0] W13,
    input  logic [WIDTH-1:0] W14,
    input  logic [WIDTH-1:0] W15,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0]     w_in [BUF_DEPTH];
    logic [WIDTH-1:0]     snapshot_reg [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] mask_reg;
    logic [BUF_DEPTH-1:0] mask_next;
    logic [BUF_IDX_W-1:0] index_reg;
    state_t               state_reg;

    logic [BUF_IDX_W-1:0] first_index;
    logic                 first_none;
    logic [BUF_IDX_W-1:0] adv_index;
    logic                 adv_none;

    assign w_in[0]  = W0;
    assign w_in[1]  = W1;
    assign w_in[2]  = W2;
    assign w_in[3]  = W3;
    assign w_in[4]  = W4;
    assign w_in[5]  = W5;
    assign w_in[6]  = W6;
    assign w_in[7]  = W7;
    assign w_in[8]  = W8;
    assign w_in[9]  = W9;
    assign w_in[10] = W10;
    assign w_in[11] = W11;
    assign w_in[12] = W12;
    assign w_in[13] = W13;
    assign w_in[14] = W14;
    assign w_in[15] = W15;

    // Emit mask for a new capture: every entry, or only the non-zero ones.
    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_mask
            assign mask_next[gi] = (SKIP_ZERO == 0) || (w_in[gi] != '0);
        end
    endgenerate

    // First entry of the stream being captured (inclusive search from 0).
    buffer_reader_next_set_finder u_first (
        .mask       (mask_next),
        .from_index ('0),
        .inclusive  (1'b1),
        .nxt_index  (first_index),
        .none       (first_none)
    );

    // Successor of the current entry; its none flag doubles as out_last.
    buffer_reader_next_set_finder u_advance (
        .mask       (mask_reg),
        .from_index (index_reg),
        .inclusive  (1'b0),
        .nxt_index  (adv_index),
        .none       (adv_none)
    );

    // Control FSM with snapshot, mask and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
            index_reg <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                snapshot_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < BUF_DEPTH; i++) begin
                            snapshot_reg[i] <= w_in[i];
                        end
                        mask_reg  <= mask_next;
                        index_reg <= first_index;
                        state_reg <= first_none ? DONE : STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (adv_none) begin
                            state_reg <= DONE;
                        end else begin
                            index_reg <= adv_index;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so out_ready never reaches out_valid.
    assign out_valid = (state_reg == STREAM);
    assign out_data  = out_valid ? snapshot_reg[index_reg] : '0;
    assign out_index = out_valid ? index_reg : '0;
    assign out_last  = out_valid && adv_none;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_buffer_reader.sv
// Scoreboard bench: two readers (SKIP_ZERO=0 and 1) share stimulus; the expected
// stream of each is derived from the buffer contents at start and checked by a monitor.
module tb_buffer_reader;

    typedef struct packed {
        logic [3:0] idx;
        logic [4:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rdy;
    logic [4:0] w [16];
    logic [4:0] od [2];
    logic [3:0] oi [2];
    logic       ov [2];
    logic       ol [2];
    logic       bz [2];
    logic       dn [2];

    exp_t q0[$];
    exp_t q1[$];
    bit   pending [2];
    bit   stall [2];
    bit   last_seen [2];
    exp_t held [2];
    int   n_vec = 0;
    int   n_err = 0;
    int   rmode = 0;
    int   rcnt = 0;

    always #5 clk = ~clk;

    buffer_reader #(.WIDTH(5), .SKIP_ZERO(0)) u0 (
        .clk(clk), .rst(rst), .start(start),
        .W0(w[0]), .W1(w[1]), .W2(w[2]), .W3(w[3]), .W4(w[4]), .W5(w[5]),
        .W6(w[6]), .W7(w[7]), .W8(w[8]), .W9(w[9]), .W10(w[10]), .W11(w[11]),
        .W12(w[12]), .W13(w[13]), .W14(w[14]), .W15(w[15]),
        .out_data(od[0]), .out_index(oi[0]), .out_valid(ov[0]), .out_ready(rdy),
        .out_last(ol[0]), .busy(bz[0]), .done(dn[0])
    );

    buffer_reader #(.WIDTH(5), .SKIP_ZERO(1)) u1 (
        .clk(clk), .rst(rst), .start(start),
        .W0(w[0]), .W1(w[1]), .W2(w[2]), .W3(w[3]), .W4(w[4]), .W5(w[5]),
        .W6(w[6]), .W7(w[7]), .W8(w[8]), .W9(w[9]), .W10(w[10]), .W11(w[11]),
        .W12(w[12]), .W13(w[13]), .W14(w[14]), .W15(w[15]),
        .out_data(od[1]), .out_index(oi[1]), .out_valid(ov[1]), .out_ready(rdy),
        .out_last(ol[1]), .busy(bz[1]), .done(dn[1])
    );

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t pop_exp(int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Reference model: the stream is the list of emitted entries in index order,
    // with the final one flagged last. Instance 1 drops zero entries.
    task automatic push_model();
        for (int k = 0; k < 2; k++) begin
            exp_t tmp[$];
            for (int i = 0; i < 16; i++) begin
                if (k == 0 || w[i] != 5'd0) begin
                    tmp.push_back('{idx: i[3:0], data: w[i], last: 1'b0});
                end
            end
            if (tmp.size() > 0) tmp[tmp.size() - 1].last = 1'b1;
            foreach (tmp[j]) begin
                if (k == 0) q0.push_back(tmp[j]);
                else        q1.push_back(tmp[j]);
            end
            pending[k] = 1'b1;
        end
    endtask

    // Ready driver: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
    initial begin : ready_drv
        rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (rcnt % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks hold/done behaviour.
    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int k = 0; k < 2; k++) begin
                    stall[k] = 1'b0;
                    last_seen[k] = 1'b0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    a = '{idx: oi[k], data: od[k], last: ol[k]};
                    if (last_seen[k]) begin
                        chk($sformatf("done_after_last%0d", k), int'(dn[k]), 1);
                        last_seen[k] = 1'b0;
                    end
                    if (stall[k]) begin
                        chk($sformatf("hold_valid%0d", k), int'(ov[k]), 1);
                        chk($sformatf("hold_word%0d", k), int'(a), int'(held[k]));
                    end
                    if (dn[k]) begin
                        chk($sformatf("done_expected%0d", k), int'(pending[k]), 1);
                        chk($sformatf("done_queue_empty%0d", k), qsize(k), 0);
                        chk($sformatf("done_no_valid%0d", k), int'(ov[k]), 0);
                        pending[k] = 1'b0;
                    end
                    if (ov[k] && rdy) begin
                        $display("t=%0t dut%0d index=%0d data=%0d last=%0d",
                                 $time, k, oi[k], od[k], ol[k]);
                        if (qsize(k) == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL extra_word%0d: got index %0d data %0d, expected no word",
                                     k, oi[k], od[k]);
                        end else begin
                            e = pop_exp(k);
                            chk($sformatf("word_index%0d", k), int'(oi[k]), int'(e.idx));
                            chk($sformatf("word_data%0d", k), int'(od[k]), int'(e.data));
                            chk($sformatf("word_last%0d", k), int'(ol[k]), int'(e.last));
                            if (e.last) last_seen[k] = 1'b1;
                        end
                    end
                    stall[k] = ov[k] && !rdy;
                    held[k]  = a;
                end
            end
        end
    end

    // All tasks below start and end at posedge+1.
    task automatic do_start();
        start = 1'b1;
        push_model();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (!bz[0] && !bz[1]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: got busy=%0d/%0d, expected idle", bz[0], bz[1]);
        end
    endtask

    task automatic wait_index0(input int idx);
        bit ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (ov[0] && oi[0] == idx[3:0]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL index_timeout: got index %0d, expected %0d", oi[0], idx);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_valid%0d", tag, k), int'(ov[k]), 0);
            chk($sformatf("%s_last%0d", tag, k), int'(ol[k]), 0);
            chk($sformatf("%s_busy%0d", tag, k), int'(bz[k]), 0);
            chk($sformatf("%s_done%0d", tag, k), int'(dn[k]), 0);
            chk($sformatf("%s_data%0d", tag, k), int'(od[k]), 0);
            chk($sformatf("%s_index%0d", tag, k), int'(oi[k]), 0);
        end
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 16; i++) w[i] = 5'(i + 1);
    endtask

    initial begin : stim
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) w[i] = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain stream, first-word latency of one cycle.
        set_ramp();
        rmode = 0;
        do_start();
        chk("first_latency", int'(ov[0]), 1);
        wait_idle();

        // Backpressure with ready pattern 1,0,0.
        rmode = 1;
        do_start();
        wait_idle();

        // Zero skip.
        rmode = 0;
        for (int i = 0; i < 16; i++) w[i] = 5'd0;
        w[3] = 5'd7;
        w[9] = 5'd2;
        w[15] = 5'd31;
        do_start();
        wait_idle();

        // Empty stream on the skipping instance.
        for (int i = 0; i < 16; i++) w[i] = 5'd0;
        do_start();
        @(negedge clk);
        chk("empty_done", int'(dn[1]), 1);
        chk("empty_valid", int'(ov[1]), 0);
        @(posedge clk);
        #1;
        wait_idle();

        // Snapshot isolation: W5 changes from 4 to 9 mid-stream.
        set_ramp();
        w[5] = 5'd4;
        do_start();
        repeat (2) @(posedge clk);
        #1;
        w[5] = 5'd9;
        wait_idle();

        // Reset mid-stream at index 6, then a fresh stream.
        set_ramp();
        do_start();
        wait_index0(6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q0.delete();
        q1.delete();
        pending[0] = 1'b0;
        pending[1] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("abort");
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        do_start();
        chk("restart_index", int'(oi[0]), 0);
        wait_idle();

        // Start while busy is ignored; a later start begins a new stream.
        do_start();
        wait_index0(2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        @(posedge clk);
        #1;
        do_start();
        wait_idle();

        // Randomized buffers and ready patterns.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) begin
                w[i] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            end
            rmode = int'($urandom_range(0, 2));
            do_start();
            if ($urandom_range(0, 1) == 1) begin
                repeat (3) @(posedge clk);
                #1;
                w[$urandom_range(0, 15)] = 5'($urandom_range(0, 31));
            end
            wait_idle();
        end

        rmode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue0", q0.size(), 0);
        chk("final_queue1", q1.size(), 0);
        chk("final_pending0", int'(pending[0]), 0);
        chk("final_pending1", int'(pending[1]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/buffer_reader.md
# buffer_reader

Consumer for the 16-entry parallel weight buffer. On `start` it snapshots the 16 words on `W0`..`W15` and streams them out, one word per handshake, over a valid/ready interface. It sits between the `Buffer` block and the serial datapath that consumes weights. Optional zero-skipping drops entries equal to zero from the stream.

## Interface
- `WIDTH`, 5: bits per buffer word.
- `SKIP_ZERO`, 0: 1 means entries equal to 0 are not emitted.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a snapshot-and-stream; sampled only in IDLE.
- `W0`..`W15`  in  WIDTH each  parallel buffer words.
- `out_data`  out  WIDTH  current streamed word.
- `out_index`  out  4  buffer index of `out_data`.
- `out_valid`  out  1  `out_data`/`out_index`/`out_last` are valid.
- `out_ready`  in  1  consumer accepts the word when high with `out_valid`.
- `out_last`  out  1  current word is the final one of this stream.
- `busy`  out  1  high in STREAM and DONE.
- `done`  out  1  one-cycle pulse after the final handshake, or after an empty stream.

## Operation
- States: IDLE, STREAM, DONE.
- **IDLE, `start`=1:**
  - Capture all 16 words into the snapshot registers.
  - Build the 16-bit emit mask. Bit i = 1 when SKIP_ZERO=0, or when Wi≠0.
  - Index register = lowest set mask bit.
  - Go to STREAM. If the mask is all zero, go to DONE instead.
- **STREAM:**
  - `out_valid`=1.
  - `out_data` = snapshot[index]; `out_index` = index.
  - `out_last`=1 when no mask bit above index is set.
- **Handshake** (`out_valid` and `out_ready` both high):
  - Not last: index moves to the next set mask bit above the current one.
  - Last: go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored while `busy`=1. It is not queued.
- Changes on `W0`..`W15` after capture do not affect the stream in flight.
- With SKIP_ZERO=0 the stream is always 16 words, index 0..15 in order.
- Reset values, including reset mid-stream:
  - State IDLE.
  - `out_valid`, `out_last`, `busy`, `done` = 0.
  - `out_data`, `out_index` = 0.
  - Snapshot, mask and index cleared.
  - No `done` pulse for an aborted stream.
- `rst` has priority over `start` and over the handshake in the same cycle.

## Timing
- `start` sampled at edge T puts `out_valid` high in cycle T+1. First-word latency is 1 cycle.
- Throughput is one word per cycle while `out_ready` stays high.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_index` and `out_last` hold stable. `out_valid` does not drop until the handshake.
- Final handshake at edge T: `done`=1 during cycle T+1, IDLE from T+2.
- A new `start` is accepted at edge T+2 at the earliest.
- Full 16-word stream with `out_ready` held high: 16 STREAM cycles, 1 DONE cycle, 18 cycles from `start` to IDLE.
- Empty stream (all zero with SKIP_ZERO=1): `start` at T, `done` in T+1, `out_valid` never rises.
- All outputs are registered or decoded from registered state only. No combinational path from `out_ready` to `out_valid`.

## Structure
- Shared package holds:
  - `BUF_DEPTH` = 16 and `BUF_IDX_W` = 4.
  - The state enum {IDLE, STREAM, DONE}.
  - `WORD_W` = 5, shared with `Buffer`.
- One sub-module is natural: `next_set_finder`.
  - Inputs: 16-bit mask and a 4-bit start index.
  - Outputs: next set index above the start index, and a `none` flag.
  - Also serves the initial lowest-bit search (search from "-1"), so it provides both `out_last` and index advance.

## Test plan
- **Plain stream:** SKIP_ZERO=0, Wi=i+1, `out_ready`=1, pulse `start`.
  - 16 words 1..16 with indices 0..15 on consecutive cycles.
  - `out_last` only at index 15; `done` one cycle later.
- **Backpressure:** same inputs, `out_ready` toggling 1,0,0,1,…
  - Each word is held stable across stalled cycles.
  - No word is dropped or duplicated; order and total count of 16 are preserved.
- **Zero skip:** SKIP_ZERO=1, W3=7, W9=2, W15=31, all others 0.
  - Exactly three words: (3,7), (9,2), (15,31).
  - `out_last` only on (15,31).
- **Empty and snapshot isolation:**
  - SKIP_ZERO=1 with all W=0: `done` in the cycle after `start`, `out_valid` stays 0.
  - Change W5 from 4 to 9 during a stream: index 5 still emits 4.
- **Reset mid-stream:** assert `rst` at index 6.
  - All outputs are 0 the next cycle; no `done` pulse.
  - A fresh `start` restarts from index 0.
- **Start while busy:** pulse `start` at index 2.
  - Ignored: no restart, index sequence unaffected.
  - A second `start` two cycles after `done` begins a new 16-word stream.
